// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with single-cycle add/sub/logic ops, a shift-add
// multiplier (one bit per cycle) and an optional restoring divider.
//
// Build option: define SEQ_ALU_DIV_EN to include the divider (DIVU/DIVS and
// divide-by-zero handling). Without it the DIV state and divider datapath
// are removed, opcodes 10/11 behave as undefined opcodes and div_zero is 0.
//
// Timing: start is sampled only in IDLE. Single-cycle results are registered
// on the start edge and done pulses for the following cycle. Multi-cycle ops
// raise busy from the start edge and register results WIDTH edges later.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             carry_out,
    output logic             zero_out,
    output logic             neg_out,
    output logic             over_out,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,
        OP_ADDC = 5'd1,
        OP_SUB  = 5'd2,
        OP_SUBC = 5'd3,
        OP_AND  = 5'd4,
        OP_OR   = 5'd5,
        OP_XOR  = 5'd6,
        OP_COMP = 5'd7,
        OP_MULU = 5'd8,
        OP_MULS = 5'd9,
        OP_DIVU = 5'd10,
        OP_DIVS = 5'd11
    } op_e;

`ifdef SEQ_ALU_DIV_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1
    } state_e;
`endif

    // Magnitude of a two's-complement value; the most-negative value maps to
    // 2^(WIDTH-1), which is still representable as an unsigned WIDTH value.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e            state_q;
    logic [CW-1:0]     count_q;
    logic [WIDTH-1:0]  opnd_q;     // multiplicand / divisor magnitude
    logic [WIDTH-1:0]  hi_q;       // product high half / partial remainder
    logic [WIDTH-1:0]  lo_q;       // multiplier bits / dividend-quotient bits
    logic              neg_lo_q;   // negate product or quotient at the end
    logic              signed_q;   // MULS rather than MULU
`ifdef SEQ_ALU_DIV_EN
    logic              neg_hi_q;   // negate remainder at the end
    logic              ovf_q;      // most-negative / -1 special case
`endif

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    logic             cin_add;
    logic             cin_sub;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_diff;
    logic             add_ovf;
    logic             sub_ovf;

    assign cin_add  = (op == OP_ADDC) & carry_in;
    assign cin_sub  = (op == OP_SUBC) & carry_in;
    assign add_sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin_add};
    assign sub_diff = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin_sub};
    assign add_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
    assign sub_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (sub_diff[WIDTH-1] != a[WIDTH-1]);

    logic [WIDTH-1:0] sc_result;
    logic [WIDTH-1:0] sc_hi;
    logic [WIDTH-1:0] sc_flag_src;
    logic             sc_carry;
    logic             sc_over;
    logic             sc_dz;
    logic             sc_zero;
    logic             sc_neg;
    logic             sc_multi;

    // Decode the opcode into a complete single-cycle outcome, or flag it as multi-cycle.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value unassigned (no latch).
        sc_result   = '0;
        sc_hi       = '0;
        sc_flag_src = '0;
        sc_carry    = 1'b0;
        sc_over     = 1'b0;
        sc_dz       = 1'b0;
        sc_multi    = 1'b0;
        case (op)
            OP_ADD, OP_ADDC: begin
                sc_result   = add_sum[WIDTH-1:0];
                sc_flag_src = add_sum[WIDTH-1:0];
                sc_carry    = add_sum[WIDTH];
                sc_over     = add_ovf;
            end
            OP_SUB, OP_SUBC: begin
                sc_result   = sub_diff[WIDTH-1:0];
                sc_flag_src = sub_diff[WIDTH-1:0];
                sc_carry    = sub_diff[WIDTH];
                sc_over     = sub_ovf;
            end
            OP_COMP: begin
                // Passes a through but reports the flags of a - b.
                sc_result   = a;
                sc_flag_src = sub_diff[WIDTH-1:0];
                sc_carry    = sub_diff[WIDTH];
                sc_over     = sub_ovf;
            end
            OP_AND: begin
                sc_result   = a & b;
                sc_flag_src = a & b;
            end
            OP_OR: begin
                sc_result   = a | b;
                sc_flag_src = a | b;
            end
            OP_XOR: begin
                sc_result   = a ^ b;
                sc_flag_src = a ^ b;
            end
            OP_MULU, OP_MULS: begin
                sc_multi = 1'b1;
            end
`ifdef SEQ_ALU_DIV_EN
            OP_DIVU, OP_DIVS: begin
                if (b == '0) begin
                    // Divide by zero completes at once with a recognisable pattern.
                    sc_result   = '1;
                    sc_hi       = a;
                    sc_flag_src = '1;
                    sc_dz       = 1'b1;
                end else begin
                    sc_multi = 1'b1;
                end
            end
`endif
            default: begin
                // Undefined opcodes produce zero and flags derived from zero.
            end
        endcase
        sc_zero = (sc_flag_src == '0);
        sc_neg  = sc_flag_src[WIDTH-1];
    end

    // ------------------------------------------------------------------
    // Multiplier step and final correction
    // ------------------------------------------------------------------
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_prod;
    logic [2*WIDTH-1:0] mul_final;
    logic [WIDTH-1:0]   mul_hi;
    logic [WIDTH-1:0]   mul_lo;
    logic               mul_carry;
    logic               mul_over;

    // Add the multiplicand when the current multiplier bit is set, then shift right.
    assign mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : {WIDTH{1'b0}})};
    assign mul_prod  = {mul_sum, lo_q[WIDTH-1:1]};
    assign mul_final = neg_lo_q ? -mul_prod : mul_prod;
    assign mul_hi    = mul_final[2*WIDTH-1:WIDTH];
    assign mul_lo    = mul_final[WIDTH-1:0];
    assign mul_carry = !signed_q && (mul_hi != '0);
    assign mul_over  = signed_q && (mul_hi != {WIDTH{mul_lo[WIDTH-1]}});

`ifdef SEQ_ALU_DIV_EN
    // ------------------------------------------------------------------
    // Restoring divider step and final sign correction
    // ------------------------------------------------------------------
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem_next;
    logic [WIDTH-1:0] div_quo_next;
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH-1:0] div_rem;

    // Bring in the next dividend bit and subtract the divisor when it fits.
    // The partial remainder is always below the divisor, so WIDTH bits suffice.
    assign div_shift    = {hi_q, lo_q[WIDTH-1]};
    assign div_ge       = (div_shift >= {1'b0, opnd_q});
    assign div_rem_next = div_ge ? (div_shift[WIDTH-1:0] - opnd_q) : div_shift[WIDTH-1:0];
    assign div_quo_next = {lo_q[WIDTH-2:0], div_ge};
    assign div_quo      = neg_lo_q ? -div_quo_next : div_quo_next;
    assign div_rem      = neg_hi_q ? -div_rem_next : div_rem_next;
`endif

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    // Sequence operations, step the iterative datapath and register all outputs.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (!reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_lo_q  <= 1'b0;
            signed_q  <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
            neg_hi_q  <= 1'b0;
            ovf_q     <= 1'b0;
`endif
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            carry_out <= 1'b0;
            zero_out  <= 1'b0;
            neg_out   <= 1'b0;
            over_out  <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (!sc_multi) begin
                            result    <= sc_result;
                            result_hi <= sc_hi;
                            carry_out <= sc_carry;
                            zero_out  <= sc_zero;
                            neg_out   <= sc_neg;
                            over_out  <= sc_over;
                            div_zero  <= sc_dz;
                            done      <= 1'b1;
                        end else begin
                            busy    <= 1'b1;
                            count_q <= '0;
                            hi_q    <= '0;
                            if (op == OP_MULU || op == OP_MULS) begin
                                state_q  <= S_MUL;
                                signed_q <= (op == OP_MULS);
                                if (op == OP_MULS) begin
                                    opnd_q   <= abs_val(a);
                                    lo_q     <= abs_val(b);
                                    neg_lo_q <= a[WIDTH-1] ^ b[WIDTH-1];
                                end else begin
                                    opnd_q   <= a;
                                    lo_q     <= b;
                                    neg_lo_q <= 1'b0;
                                end
                            end
`ifdef SEQ_ALU_DIV_EN
                            else begin
                                state_q  <= S_DIV;
                                signed_q <= 1'b0;
                                if (op == OP_DIVS) begin
                                    opnd_q   <= abs_val(b);
                                    lo_q     <= abs_val(a);
                                    neg_lo_q <= a[WIDTH-1] ^ b[WIDTH-1];
                                    neg_hi_q <= a[WIDTH-1];
                                    ovf_q    <= (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
                                end else begin
                                    opnd_q   <= b;
                                    lo_q     <= a;
                                    neg_lo_q <= 1'b0;
                                    neg_hi_q <= 1'b0;
                                    ovf_q    <= 1'b0;
                                end
                            end
`endif
                        end
                    end
                end
                S_MUL: begin
                    hi_q    <= mul_prod[2*WIDTH-1:WIDTH];
                    lo_q    <= mul_prod[WIDTH-1:0];
                    count_q <= count_q + CW'(1);
                    if (count_q == CW'(WIDTH - 1)) begin
                        state_q   <= S_IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        result    <= mul_lo;
                        result_hi <= mul_hi;
                        carry_out <= mul_carry;
                        zero_out  <= (mul_lo == '0);
                        neg_out   <= mul_lo[WIDTH-1];
                        over_out  <= mul_over;
                        div_zero  <= 1'b0;
                    end
                end
`ifdef SEQ_ALU_DIV_EN
                S_DIV: begin
                    hi_q    <= div_rem_next;
                    lo_q    <= div_quo_next;
                    count_q <= count_q + CW'(1);
                    if (count_q == CW'(WIDTH - 1)) begin
                        state_q   <= S_IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        result    <= div_quo;
                        result_hi <= div_rem;
                        carry_out <= 1'b0;
                        zero_out  <= (div_quo == '0);
                        neg_out   <= div_quo[WIDTH-1];
                        over_out  <= ovf_q;
                        div_zero  <= 1'b0;
                    end
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH=32. Divider vectors are
// selected by SEQ_ALU_DIV_EN to match the build of the design under test.
module tb_seq_alu;

    localparam int WIDTH = 32;

    // Flag vector order used by expectations: {carry, zero, neg, over, div_zero}
    localparam logic [4:0] F_C = 5'b10000;
    localparam logic [4:0] F_Z = 5'b01000;
    localparam logic [4:0] F_N = 5'b00100;
    localparam logic [4:0] F_O = 5'b00010;
    localparam logic [4:0] F_D = 5'b00001;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [4:0]       op = '0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             carry_in = 1'b0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             carry_out;
    logic             zero_out;
    logic             neg_out;
    logic             over_out;
    logic             div_zero;

    int n_checks = 0;
    int n_fail   = 0;

    seq_alu #(.WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .result_hi (result_hi),
        .carry_out (carry_out),
        .zero_out  (zero_out),
        .neg_out   (neg_out),
        .over_out  (over_out),
        .div_zero  (div_zero)
    );

    initial forever #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] flags();
        return {carry_out, zero_out, neg_out, over_out, div_zero};
    endfunction

    task automatic check_res(input string tag, input logic [WIDTH-1:0] er,
                             input logic [WIDTH-1:0] eh, input logic [4:0] ef);
        check({tag, "_result"}, 64'(result), 64'(er));
        check({tag, "_result_hi"}, 64'(result_hi), 64'(eh));
        check({tag, "_flags"}, 64'(flags()), 64'(ef));
    endtask

    // Present a request for one edge; returns at 1 time unit after that edge.
    task automatic start_op(input logic [4:0] o, input logic [WIDTH-1:0] va,
                            input logic [WIDTH-1:0] vb, input logic cin);
        op       = o;
        a        = va;
        b        = vb;
        carry_in = cin;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic run_single(input string tag, input logic [4:0] o, input logic [WIDTH-1:0] va,
                              input logic [WIDTH-1:0] vb, input logic cin,
                              input logic [WIDTH-1:0] er, input logic [WIDTH-1:0] eh,
                              input logic [4:0] ef);
        start_op(o, va, vb, cin);
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check_res(tag, er, eh, ef);
        @(posedge clock);
        #1;
        check({tag, "_done_drop"}, 64'(done), 64'd0);
        check({tag, "_hold"}, 64'(result), 64'(er));
    endtask

    task automatic run_multi(input string tag, input logic [4:0] o, input logic [WIDTH-1:0] va,
                             input logic [WIDTH-1:0] vb, input bit mid_start,
                             input logic [WIDTH-1:0] er, input logic [WIDTH-1:0] eh,
                             input logic [4:0] ef);
        int n;
        bit overlap;
        start_op(o, va, vb, 1'b0);
        check({tag, "_busy_start"}, 64'(busy), 64'd1);
        check({tag, "_done_start"}, 64'(done), 64'd0);
        n = 0;
        overlap = 1'b0;
        while (busy && n < 100) begin
            if (mid_start && n == 5) begin
                op    = 5'd0;
                a     = 32'd2;
                b     = 32'd3;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clock);
            #1;
            n++;
            if (busy && done) overlap = 1'b1;
        end
        start = 1'b0;
        check({tag, "_cycles"}, 64'(n), 64'(WIDTH));
        check({tag, "_overlap"}, 64'(overlap), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd1);
        check_res(tag, er, eh, ef);
        @(posedge clock);
        #1;
        check({tag, "_done_drop"}, 64'(done), 64'd0);
    endtask

    initial begin
        int seen;

        // Reset with a pending request: nothing may happen.
        reset = 1'b0;
        start = 1'b1;
        op    = 5'd0;
        a     = 32'd1;
        b     = 32'd1;
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check_res("rst", '0, '0, 5'b0);
        start = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("rst_release_done", 64'(done), 64'd0);

        // Add/sub family and overflow/carry boundaries.
        run_single("add_ovf", 5'd0, 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, '0, F_N | F_O);
        run_single("addc_wrap", 5'd1, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0, '0, F_C | F_Z);
        run_single("add_nocin", 5'd0, 32'h10, 32'h20, 1'b1, 32'h30, '0, 5'b0);
        run_single("sub_borrow", 5'd2, 32'h5, 32'h7, 1'b0, 32'hFFFF_FFFE, '0, F_C | F_N);
        run_single("subc", 5'd3, 32'h10, 32'h3, 1'b1, 32'hC, '0, 5'b0);
        run_single("sub_ovf", 5'd2, 32'h8000_0000, 32'h1, 1'b0, 32'h7FFF_FFFF, '0, F_O);
        run_single("comp_eq", 5'd7, 32'h5, 32'h5, 1'b0, 32'h5, '0, F_Z);
        run_single("comp_lt", 5'd7, 32'h3, 32'h9, 1'b0, 32'h3, '0, F_C | F_N);

        // Logic ops.
        run_single("and", 5'd4, 32'hF0F0, 32'hFF00, 1'b0, 32'hF000, '0, 5'b0);
        run_single("or", 5'd5, 32'hF0F0_0000, 32'h0F0F, 1'b0, 32'hF0F0_0F0F, '0, F_N);
        run_single("xor", 5'd6, 32'h1234, 32'h1234, 1'b1, 32'h0, '0, F_Z);

        // Multiplier, including a request that arrives mid-operation.
        run_multi("mulu", 5'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h1, 32'hFFFF_FFFE, F_C);
        run_single("undef_after_mul", 5'd31, 32'h1, 32'h1, 1'b0, 32'h0, '0, F_Z);
        run_multi("muls", 5'd9, 32'hFFFF_FFFE, 32'h3, 1'b1, 32'hFFFF_FFFA, 32'hFFFF_FFFF, F_N);
        run_multi("muls_ovf", 5'd9, 32'h4000_0000, 32'h2, 1'b0, 32'h8000_0000, 32'h0, F_N | F_O);

`ifdef SEQ_ALU_DIV_EN
        run_multi("divu", 5'd10, 32'd100, 32'd7, 1'b0, 32'hE, 32'h2, 5'b0);
        run_multi("divs_neg", 5'd11, 32'hFFFF_FFF9, 32'h2, 1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, F_N);
        run_multi("divs_negb", 5'd11, 32'h7, 32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFD, 32'h1, F_N);
        run_multi("divs_min", 5'd11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 32'h0, F_N | F_O);
        run_single("divu_zero", 5'd10, 32'h1234, 32'h0, 1'b0, 32'hFFFF_FFFF, 32'h1234, F_N | F_D);
        run_single("dz_clear", 5'd0, 32'h1, 32'h1, 1'b0, 32'h2, '0, 5'b0);
`else
        run_single("divu_absent", 5'd10, 32'd10, 32'd2, 1'b0, 32'h0, '0, F_Z);
`endif

        // Reset in the middle of a multiply aborts it without a done pulse.
        start_op(5'd8, 32'h5, 32'h7, 1'b0);
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b0;
        start = 1'b1;
        op    = 5'd0;
        a     = 32'd9;
        b     = 32'd9;
        @(posedge clock);
        #1;
        start = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check_res("abort", '0, '0, 5'b0);
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (done || busy) seen++;
        end
        check("abort_no_done", 64'(seen), 64'd0);
        run_single("add_after_abort", 5'd0, 32'd2, 32'd3, 1'b0, 32'd5, '0, 5'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit so the bench always ends on its own.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
